// File: rtl/fighter_pkg.sv
// Shared types and constants for the per-player fighter action sequencer.
// State encoding is fixed because the sprite selector decodes it directly.
package fighter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WALK     = 3'd1,
        ST_STARTUP  = 3'd2,
        ST_ACTIVE   = 3'd3,
        ST_RECOVERY = 3'd4,
        ST_HITSTUN  = 3'd5
    } state_t;

    localparam int FLOOR_Y = 48;

    localparam int DEF_STARTUP_TICKS  = 2;
    localparam int DEF_ACTIVE_TICKS   = 3;
    localparam int DEF_RECOVERY_TICKS = 4;
    localparam int DEF_HITSTUN_TICKS  = 6;
    localparam int DEF_CNT_W          = 4;

    // Anything other than standing or walking locks out player control.
    function automatic logic is_busy(input state_t s);
        return !(s == ST_IDLE || s == ST_WALK);
    endfunction

endpackage

// File: rtl/edge_latch.sv
// Rising-edge detector feeding a sticky flag; a new edge wins over a
// simultaneous clear so a press landing on a tick clock is not lost.
module edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic din,
    input  logic clr,
    output logic flag
);

    logic prev;

    // prev tracks din even in reset so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= din;
            flag <= 1'b0;
        end else begin
            prev <= din;
            if (din && !prev) begin
                flag <= 1'b1;
            end else if (clr) begin
                flag <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: buttons and hit events in, physics strobes,
// hitbox enable and debug state out, all advanced on the game tick.
module fighter_action_ctrl
    import fighter_pkg::*;
#(
    parameter int STARTUP_TICKS  = DEF_STARTUP_TICKS,
    parameter int ACTIVE_TICKS   = DEF_ACTIVE_TICKS,
    parameter int RECOVERY_TICKS = DEF_RECOVERY_TICKS,
    parameter int HITSTUN_TICKS  = DEF_HITSTUN_TICKS,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic       btn_attack,
    input  logic       on_floor,
    input  logic       facing_right,
    input  logic       hit_taken,
    output logic       moving_left,
    output logic       moving_right,
    output logic       is_jumping,
    output logic       attack_active,
    output logic       busy,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] STARTUP_LOAD  = CNT_W'(STARTUP_TICKS - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LOAD   = CNT_W'(ACTIVE_TICKS - 1);
    localparam logic [CNT_W-1:0] RECOVERY_LOAD = CNT_W'(RECOVERY_TICKS - 1);
    localparam logic [CNT_W-1:0] HITSTUN_LOAD  = CNT_W'(HITSTUN_TICKS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic              atk_buf, atk_buf_d;
    logic              left_d, right_d, jump_d, active_d, busy_d;
    logic              jump_pend, atk_pend, hit_pend;
    logic              expired;

    // Every tick consumes whatever events were latched since the last one.
    edge_latch u_jump (
        .clk   (clk),
        .reset (reset),
        .din   (btn_jump),
        .clr   (tick),
        .flag  (jump_pend)
    );

    edge_latch u_attack (
        .clk   (clk),
        .reset (reset),
        .din   (btn_attack),
        .clr   (tick),
        .flag  (atk_pend)
    );

    edge_latch u_hit (
        .clk   (clk),
        .reset (reset),
        .din   (hit_taken),
        .clr   (tick),
        .flag  (hit_pend)
    );

    assign expired = (timer_q == '0);
    assign state   = state_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        atk_buf_d = atk_buf;
        left_d    = moving_left;
        right_d   = moving_right;
        jump_d    = 1'b0;
        active_d  = 1'b0;

        if (hit_pend) begin
            // Knockback direction is latched on entry; re-hits only extend the stun.
            state_d   = ST_HITSTUN;
            timer_d   = HITSTUN_LOAD;
            atk_buf_d = 1'b0;
            if (state_q != ST_HITSTUN) begin
                left_d  = facing_right;
                right_d = ~facing_right;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (atk_pend) begin
                        state_d = ST_STARTUP;
                        timer_d = STARTUP_LOAD;
                        left_d  = 1'b0;
                        right_d = 1'b0;
                    end else begin
                        jump_d = jump_pend && on_floor;
                        if (btn_left && !btn_right) begin
                            state_d = ST_WALK;
                            left_d  = 1'b1;
                            right_d = 1'b0;
                        end else if (btn_right && !btn_left) begin
                            state_d = ST_WALK;
                            left_d  = 1'b0;
                            right_d = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            left_d  = 1'b0;
                            right_d = 1'b0;
                        end
                    end
                end

                ST_STARTUP: begin
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    if (expired) begin
                        state_d  = ST_ACTIVE;
                        timer_d  = ACTIVE_LOAD;
                        active_d = 1'b1;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end

                ST_ACTIVE: begin
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    if (expired) begin
                        state_d = ST_RECOVERY;
                        timer_d = RECOVERY_LOAD;
                    end else begin
                        timer_d  = timer_q - CNT_W'(1);
                        active_d = 1'b1;
                    end
                end

                ST_RECOVERY: begin
                    // A press on the expiry tick itself counts as buffered.
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    if (expired) begin
                        if (atk_buf || atk_pend) begin
                            state_d   = ST_STARTUP;
                            timer_d   = STARTUP_LOAD;
                            atk_buf_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                        if (atk_pend) begin
                            atk_buf_d = 1'b1;
                        end
                    end
                end

                ST_HITSTUN: begin
                    if (expired) begin
                        state_d = ST_IDLE;
                        left_d  = 1'b0;
                        right_d = 1'b0;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end

                default: begin
                    state_d   = ST_IDLE;
                    timer_d   = '0;
                    atk_buf_d = 1'b0;
                    left_d    = 1'b0;
                    right_d   = 1'b0;
                end
            endcase
        end

        busy_d = is_busy(state_d);
    end

    // Everything visible to physics moves only on a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            atk_buf       <= 1'b0;
            moving_left   <= 1'b0;
            moving_right  <= 1'b0;
            is_jumping    <= 1'b0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
        end else if (tick) begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            atk_buf       <= atk_buf_d;
            moving_left   <= left_d;
            moving_right  <= right_d;
            is_jumping    <= jump_d;
            attack_active <= active_d;
            busy          <= busy_d;
        end
    end

endmodule
